// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding definitions for the instruction loader and the CPU control decoder.
// Pure declarations: no logic, no latency, no flow control.
// Mnemonics, opcodes, the R-type function prefix and error causes live here so both ends agree.
package instr_encoder_loader_pkg;

    typedef enum logic [3:0] {
        MN_RTYPE = 4'd0,
        MN_LI    = 4'd1,
        MN_LUI   = 4'd2,
        MN_ADDI  = 4'd3,
        MN_ANDI  = 4'd4,
        MN_ORI   = 4'd5,
        MN_B     = 4'd6,
        MN_BEQ   = 4'd7,
        MN_BNE   = 4'd8,
        MN_LB    = 4'd9,
        MN_SB    = 4'd10,
        MN_LW    = 4'd11,
        MN_SW    = 4'd12,
        MN_NOP   = 4'd13
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [1:0] RTYPE_FUNC_PREFIX = 2'b11;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CAUSE_ZERO_BEQ = 2'd2;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_PAD,
        ST_RELEASE,
        ST_ERROR
    } state_e;

    typedef struct packed {
        logic [3:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [3:0]  alu_op;
        logic [15:0] imm;
    } instr_fields_t;

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs, rd, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_word_encoder.sv
// Purpose: combinational mnemonic/fields to 32-bit instruction word plus illegal/zero-BEQ flags.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module instr_word_encoder
    import instr_encoder_loader_pkg::*;
(
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          illegal,
    output logic          zero_beq
);

    // Operands a mnemonic does not use are encoded as zero.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fields.mnem)
            MN_RTYPE: word = {OP_RTYPE, fields.rs, fields.rd, fields.rt, 5'b0,
                              RTYPE_FUNC_PREFIX, fields.alu_op};
            MN_LI:    word = i_word(OP_LI,   5'd0,      fields.rd, fields.imm);
            MN_LUI:   word = i_word(OP_LUI,  5'd0,      fields.rd, fields.imm);
            MN_ADDI:  word = i_word(OP_ADDI, fields.rs, fields.rd, fields.imm);
            MN_ANDI:  word = i_word(OP_ANDI, fields.rs, fields.rd, fields.imm);
            MN_ORI:   word = i_word(OP_ORI,  fields.rs, fields.rd, fields.imm);
            MN_B:     word = i_word(OP_B,    5'd0,      5'd0,      fields.imm);
            MN_BEQ:   word = i_word(OP_BEQ,  fields.rs, fields.rd, fields.imm);
            MN_BNE:   word = i_word(OP_BNE,  fields.rs, fields.rd, fields.imm);
            MN_LB:    word = i_word(OP_LB,   fields.rs, fields.rd, fields.imm);
            MN_SB:    word = i_word(OP_SB,   fields.rs, fields.rd, fields.imm);
            MN_LW:    word = i_word(OP_LW,   fields.rs, fields.rd, fields.imm);
            MN_SW:    word = i_word(OP_SW,   fields.rs, fields.rd, fields.imm);
            MN_NOP:   word = '0;
            default:  illegal = 1'b1;
        endcase
    end

    // An all-zero BEQ would be indistinguishable from NOP at the decoder.
    assign zero_beq = (fields.mnem == MN_BEQ) && (word == 32'h0);

endmodule

// File: rtl/instr_encoder_loader.sv
// Purpose: encode a host instruction stream and write it sequentially into instruction memory,
// holding the CPU in reset until done (LOADER_NOP_PAD_EN: zero-fill the remaining words).
// Latency: beat accepted at N is written at N+1; backpressure: in_ready only in LOAD (1 word / 2 cycles).
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rt,
    input  logic [3:0]        in_alu_op,
    input  logic [15:0]       in_imm,
    output logic              Mem_WrEn,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_WrData,
    output logic              cpu_hold,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_cause,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [ADDR_W:0] addr_q;
    logic [ADDR_W:0] wc_q;
    logic [31:0]     wdata_q;
    logic            last_q;
    logic            hold_q;
    logic            err_q;
    logic [1:0]      cause_q;

    instr_fields_t   fields;
    logic [31:0]     enc_word;
    logic            enc_illegal;
    logic            enc_zero_beq;
    logic [ADDR_W:0] addr_inc;
    logic            at_end;
    logic            restart;

    assign fields = '{mnem: in_mnem, rs: in_rs, rd: in_rd, rt: in_rt,
                      alu_op: in_alu_op, imm: in_imm};

    instr_word_encoder u_enc (
        .fields   (fields),
        .word     (enc_word),
        .illegal  (enc_illegal),
        .zero_beq (enc_zero_beq)
    );

    assign addr_inc = addr_q + 1'b1;
    assign at_end   = (addr_inc == DEPTH_W);
    assign restart  = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        Mem_WrEn = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_d = (enc_illegal || enc_zero_beq) ? ST_ERROR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                Mem_WrEn = 1'b1;
                busy     = 1'b1;
                if (last_q) begin
`ifdef LOADER_NOP_PAD_EN
                    state_d = at_end ? ST_RELEASE : ST_PAD;
`else
                    state_d = ST_RELEASE;
`endif
                end else if (at_end) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LOAD;
                end
            end
`ifdef LOADER_NOP_PAD_EN
            ST_PAD: begin
                Mem_WrEn = 1'b1;
                busy     = 1'b1;
                if (at_end) state_d = ST_RELEASE;
            end
`endif
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            addr_q  <= '0;
            wc_q    <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            if (restart) begin
                addr_q  <= '0;
                wc_q    <= '0;
                err_q   <= 1'b0;
                cause_q <= CAUSE_NONE;
                hold_q  <= 1'b1;
            end
            if (state_q == ST_LOAD && in_valid) begin
                wdata_q <= enc_word;
                last_q  <= in_last;
                if (enc_illegal) begin
                    err_q   <= 1'b1;
                    cause_q <= CAUSE_ILLEGAL;
                end else if (enc_zero_beq) begin
                    err_q   <= 1'b1;
                    cause_q <= CAUSE_ZERO_BEQ;
                end
            end
            if (state_q == ST_WRITE) begin
                addr_q <= addr_inc;
                wc_q   <= wc_q + 1'b1;
                if (!last_q && at_end) begin
                    err_q   <= 1'b1;
                    cause_q <= CAUSE_OVERFLOW;
                end
            end
            // Padding keeps advancing the address but not the program word count.
            if (state_q == ST_PAD) addr_q <= addr_inc;
            if (state_d == ST_PAD) wdata_q <= '0;
            if (state_d == ST_RELEASE) hold_q <= 1'b0;
            if (state_d == ST_ERROR) hold_q <= 1'b1;
        end
    end

    assign Mem_Addr   = addr_q[ADDR_W-1:0];
    assign Mem_WrData = wdata_q;
    assign cpu_hold   = hold_q;
    assign err        = err_q;
    assign err_cause  = cause_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader at DEPTH=4: encoding table, hand-timed sequences, random programs.
// Honours LOADER_NOP_PAD_EN in its reference model.
module tb_instr_encoder_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              Reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_mnem;
    logic [4:0]        in_rs, in_rd, in_rt;
    logic [3:0]        in_alu_op;
    logic [15:0]       in_imm;
    logic              Mem_WrEn;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_WrData;
    logic              cpu_hold;
    logic              busy;
    logic              err;
    logic [1:0]        err_cause;
    logic [ADDR_W:0]   word_count;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_mnem(in_mnem), .in_rs(in_rs), .in_rd(in_rd), .in_rt(in_rt),
        .in_alu_op(in_alu_op), .in_imm(in_imm), .Mem_WrEn(Mem_WrEn), .Mem_Addr(Mem_Addr),
        .Mem_WrData(Mem_WrData), .cpu_hold(cpu_hold), .busy(busy), .err(err),
        .err_cause(err_cause), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mn;
        logic [4:0]  rs, rd, rt;
        logic [3:0]  alu;
        logic [15:0] imm;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t       b;
        logic [31:0] w;
        int          cause;
    } vec_t;

    int errors = 0;
    int checks = 0;

    beat_t             prog[$];
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];

    always @(negedge clk) begin
        if (Mem_WrEn) begin
            cap_addr.push_back(Mem_Addr);
            cap_data.push_back(Mem_WrData);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int mn, input int rs, input int rd, input int rt,
                                 input int alu, input int imm, input bit last);
        beat_t b;
        b.mn = 4'(mn); b.rs = 5'(rs); b.rd = 5'(rd); b.rt = 5'(rt);
        b.alu = 4'(alu); b.imm = 16'(imm); b.last = last;
        return b;
    endfunction

    // Reference encoder: opcode table plus which operand fields each mnemonic keeps.
    function automatic logic [31:0] ref_encode(input beat_t b, output bit illegal);
        int unsigned op, rs, rd, tail;
        bit ur, ud;
        illegal = 1'b0; op = 0; ur = 1'b0; ud = 1'b0;
        case (b.mn)
            4'd0:  begin op = 32; ur = 1; ud = 1; end
            4'd1:  begin op = 56; ud = 1; end
            4'd2:  begin op = 57; ud = 1; end
            4'd3:  begin op = 48; ur = 1; ud = 1; end
            4'd4:  begin op = 50; ur = 1; ud = 1; end
            4'd5:  begin op = 51; ur = 1; ud = 1; end
            4'd6:  begin op = 63; end
            4'd7:  begin op = 0;  ur = 1; ud = 1; end
            4'd8:  begin op = 1;  ur = 1; ud = 1; end
            4'd9:  begin op = 3;  ur = 1; ud = 1; end
            4'd10: begin op = 7;  ur = 1; ud = 1; end
            4'd11: begin op = 15; ur = 1; ud = 1; end
            4'd12: begin op = 31; ur = 1; ud = 1; end
            4'd13: return 32'h0;
            default: begin illegal = 1'b1; return 32'h0; end
        endcase
        rs = ur ? 32'(b.rs) : 32'd0;
        rd = ud ? 32'(b.rd) : 32'd0;
        tail = (b.mn == 4'd0) ? ((32'(b.rt) << 11) | 32'd48 | 32'(b.alu)) : 32'(b.imm);
        return (op << 26) | (rs << 21) | (rd << 16) | tail;
    endfunction

    task automatic drive(input beat_t b);
        in_mnem = b.mn; in_rs = b.rs; in_rd = b.rd; in_rt = b.rt;
        in_alu_op = b.alu; in_imm = b.imm; in_last = b.last;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Returns at a falling edge where in_ready is high, so the next rising edge accepts.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_program();
        logic [31:0] exp_w[$];
        int  exp_cause = 0;
        int  n_feed = 0;
        int  n_words;
        bit  released = 1'b0;
        bit  ill, ok, done;
        logic [31:0] w;
        for (int i = 0; i < prog.size(); i++) begin
            n_feed++;
            w = ref_encode(prog[i], ill);
            if (ill) begin exp_cause = 1; break; end
            if (prog[i].mn == 4'd7 && w == 32'h0) begin exp_cause = 2; break; end
            exp_w.push_back(w);
            if (prog[i].last) begin released = 1'b1; break; end
            if (exp_w.size() == DEPTH) begin exp_cause = 3; break; end
        end
        n_words = exp_w.size();
`ifdef LOADER_NOP_PAD_EN
        if (released) while (exp_w.size() < DEPTH) exp_w.push_back(32'h0);
`endif
        cap_addr.delete(); cap_data.delete();
        start_pulse();
        for (int i = 0; i < n_feed; i++) begin
            drive(prog[i]);
            in_valid = 1'b1;
            wait_ready(ok);
            check("beat_accept", ok, 1);
            if (!ok) break;
            @(posedge clk); #1 in_valid = 1'b0;
        end
        in_valid = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
        end
        check("load_done", done, 1);
        @(negedge clk); @(negedge clk);
        check("n_writes", cap_data.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < cap_data.size(); i++) begin
            check("wr_addr", cap_addr[i], i);
            check("wr_data", cap_data[i], exp_w[i]);
        end
        check("err", err, exp_cause != 0);
        check("err_cause", err_cause, exp_cause);
        check("word_count", word_count, n_words);
        check("cpu_hold", cpu_hold, exp_cause != 0);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wren"}, Mem_WrEn, 0);
        check({tag, "_addr"}, Mem_Addr, 0);
        check({tag, "_wdata"}, Mem_WrData, 0);
        check({tag, "_hold"}, cpu_hold, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cause"}, err_cause, 0);
        check({tag, "_wc"}, word_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[17];
        bit   ok;
        beat_t b;
        int   len;

        vt[0]  = '{mk(3, 1, 2, 0, 0, 'h0005, 1), 32'hC0220005, 0};
        vt[1]  = '{mk(0, 3, 4, 5, 1, 'h0000, 1), 32'h80642831, 0};
        vt[2]  = '{mk(0, 31, 31, 31, 15, 'hFFFF, 1), 32'h83FFF83F, 0};
        vt[3]  = '{mk(2, 7, 1, 9, 3, 'hFFFF, 1), 32'hE401FFFF, 0};
        vt[4]  = '{mk(6, 3, 4, 5, 2, 'h0010, 1), 32'hFC000010, 0};
        vt[5]  = '{mk(7, 1, 2, 0, 0, 'h0000, 1), 32'h00220000, 0};
        vt[6]  = '{mk(12, 2, 3, 1, 1, 'h0008, 1), 32'h7C430008, 0};
        vt[7]  = '{mk(11, 1, 5, 0, 0, 'h0004, 1), 32'h3C250004, 0};
        vt[8]  = '{mk(1, 9, 6, 0, 0, 'h1234, 1), 32'hE0061234, 0};
        vt[9]  = '{mk(5, 31, 31, 31, 0, 'hABCD, 1), 32'hCFFFABCD, 0};
        vt[10] = '{mk(4, 2, 3, 0, 0, 'h00FF, 1), 32'hC84300FF, 0};
        vt[11] = '{mk(9, 1, 1, 0, 0, 'hFFFF, 1), 32'h0C21FFFF, 0};
        vt[12] = '{mk(10, 4, 2, 0, 0, 'h0002, 1), 32'h1C820002, 0};
        vt[13] = '{mk(8, 0, 0, 0, 0, 'h0000, 1), 32'h04000000, 0};
        vt[14] = '{mk(13, 5, 5, 5, 5, 'hFFFF, 1), 32'h00000000, 0};
        vt[15] = '{mk(7, 0, 0, 7, 3, 'h0000, 1), 32'h00000000, 2};
        vt[16] = '{mk(15, 1, 2, 3, 4, 'h0005, 1), 32'h00000000, 1};

        Reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        @(posedge clk); #2 Reset = 1'b1;
        @(negedge clk);
        check_reset_values("post_rst");

        for (int k = 0; k < 17; k++) begin
            prog.delete();
            prog.push_back(vt[k].b);
            run_program();
            check("tbl_cause", err_cause, vt[k].cause);
            if (vt[k].cause == 0 && cap_data.size() > 0) check("tbl_word", cap_data[0], vt[k].w);
        end

        // Illegal mnemonic keeps in_ready low until a start.
        prog.delete(); prog.push_back(mk(14, 0, 0, 0, 0, 0, 1));
        run_program();
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("err_no_ready", in_ready, 0);
        in_valid = 1'b0;
        start_pulse();
        @(negedge clk);
        check("err_cleared", err, 0);
        check("err_cause_cleared", err_cause, 0);
        check("restart_ready", in_ready, 1);
        check("restart_hold", cpu_hold, 1);
        prog.delete(); prog.push_back(mk(13, 0, 0, 0, 0, 0, 1));
        run_program();

        // Two-beat program with cycle-exact latency checks.
        start_pulse();
        drive(mk(0, 3, 4, 5, 1, 0, 0));
        in_valid = 1'b1;
        wait_ready(ok);
        check("lat_accept", ok, 1);
        @(posedge clk); #1;
        check("lat_wren", Mem_WrEn, 1);
        check("lat_addr0", Mem_Addr, 0);
        check("lat_data0", Mem_WrData, 32'h80642831);
        check("lat_ready_low", in_ready, 0);
        drive(mk(12, 2, 3, 0, 0, 'h0008, 1));
        @(posedge clk); #1;
        check("lat_ready_back", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_wren1", Mem_WrEn, 1);
        check("lat_addr1", Mem_Addr, 1);
        check("lat_data1", Mem_WrData, 32'h7C430008);
        check("lat_hold_during", cpu_hold, 1);
        @(posedge clk); #1;
`ifdef LOADER_NOP_PAD_EN
        check("pad_wren2", Mem_WrEn, 1);
        check("pad_addr2", Mem_Addr, 2);
        check("pad_data2", Mem_WrData, 0);
        @(posedge clk); #1;
        check("pad_addr3", Mem_Addr, 3);
        check("pad_data3", Mem_WrData, 0);
        @(posedge clk); #1;
`endif
        check("lat_hold_fall", cpu_hold, 0);
        check("lat_wren_off", Mem_WrEn, 0);
        @(posedge clk); #1;
        check("lat_wc", word_count, 2);
        check("lat_busy", busy, 0);

        // start during LOAD is ignored: the second word still goes to address 1.
        prog.delete();
        prog.push_back(mk(11, 1, 5, 0, 0, 'h0004, 0));
        prog.push_back(mk(3, 1, 2, 0, 0, 'h0005, 1));
        cap_addr.delete(); cap_data.delete();
        start_pulse();
        drive(prog[0]); in_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drive(prog[1]); in_valid = 1'b1;
        wait_ready(ok);
        check("ign_accept", ok, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("ign_nwr", cap_data.size() >= 2, 1);
        if (cap_data.size() >= 2) check("ign_addr1", cap_addr[1], 1);
        check("ign_wc", word_count, 2);

        // Reset asserted while a write is in flight.
        start_pulse();
        drive(mk(11, 1, 5, 0, 0, 'h0004, 0)); in_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1 in_valid = 1'b0;
        check("pre_rst_wren", Mem_WrEn, 1);
        Reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        #2 Reset = 1'b1;

        // Depth boundary: full program completes; one beat too many overflows.
        prog.delete();
        for (int i = 0; i < 4; i++) prog.push_back(mk(3, i, i + 1, 0, 0, i + 16, i == 3));
        run_program();
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(mk(5, i, i, 0, 0, i, 0));
        run_program();
        check("ovf_cause", err_cause, 3);

        for (int n = 0; n < 40; n++) begin
            prog.delete();
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                b = mk($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 65535), 0);
                if ($urandom_range(0, 5) == 0) begin
                    b.mn = 4'd7; b.rs = '0; b.rd = '0; b.imm = '0;
                end
                b.last = (i == len - 1) && (len < 5 || $urandom_range(0, 1) == 1);
                prog.push_back(b);
            end
            run_program();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Encodes symbolic instructions from a host/testbench stream into 32-bit instruction words and writes them sequentially into instruction memory. It holds the CPU in reset while loading and releases it when the program is complete. It is the producing end of the instruction-word format that the CPU control decoder consumes. It sits between the host load port and the instruction-memory write port.

## Interface
Parameters:
- DEPTH, 1024, instruction memory depth in words.
- ADDR_W, $clog2(DEPTH), word address width.

Ports:
- clk  in  1  clock.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load at address 0.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  encoder can accept a beat.
- in_last  in  1  marks the final instruction of the program.
- in_mnem  in  4  mnemonic code (package enum).
- in_rs, in_rd, in_rt  in  5 each  register fields.
- in_alu_op  in  4  ALU function, used for R-type only.
- in_imm  in  16  immediate / branch offset.
- Mem_WrEn  out  1  instruction-memory write strobe.
- Mem_Addr  out  ADDR_W  write word address.
- Mem_WrData  out  32  encoded word.
- cpu_hold  out  1  held-in-reset request to the CPU.
- busy  out  1  load in progress.
- err  out  1  sticky error flag.
- err_cause  out  2  0 none, 1 illegal mnemonic, 2 zero-word beq, 3 overflow.
- word_count  out  ADDR_W+1  words written by the current load.

## Operation
- Mnemonic codes: 0 RTYPE, 1 LI, 2 LUI, 3 ADDI, 4 ANDI, 5 ORI, 6 B, 7 BEQ, 8 BNE, 9 LB, 10 SB, 11 LW, 12 SW, 13 NOP. Codes 14 and 15 are illegal.
- Opcodes [31:26]: RTYPE 100000, LI 111000, LUI 111001, ADDI 110000, ANDI 110010, ORI 110011, B 111111, BEQ 000000, BNE 000001, LB 000011, SB 000111, LW 001111, SW 011111.
- I-type layout: {op, rs[25:21], rd[20:16], imm[15:0]}.
- R-type layout: {op, rs, rd, rt[15:11], 5'b0, 2'b11, alu_op[3:0]}.
- NOP encodes to 32'h0.
- Register fields of unused operands are forced to 0.
- FSM states: IDLE, LOAD, WRITE, PAD (macro only), RELEASE, ERROR.
- IDLE: cpu_hold holds its last value (1 after reset). On start: go to LOAD, address = 0, word_count = 0, err cleared, cpu_hold = 1.
- LOAD: in_ready = 1.
  - Accepted beat (in_valid & in_ready): encode into the word register and go to WRITE.
  - Illegal mnemonic: go to ERROR, cause 1.
  - BEQ that encodes to 32'h0: go to ERROR, cause 2, because the decoder treats an all-zero word as NOP.
- WRITE: Mem_WrEn = 1 for exactly one cycle; address and word_count increment. Next state:
  - if last was set: RELEASE (or PAD with the macro);
  - else if address has reached DEPTH: ERROR, cause 3;
  - else: LOAD.
- RELEASE: cpu_hold drops to 0; next state IDLE.
- ERROR: in_ready = 0, cpu_hold = 1, err = 1. Only start or Reset leaves this state.
- start asserted in any state other than IDLE or ERROR is ignored.

## Timing
- Reset values: state IDLE, in_ready 0, Mem_WrEn 0, Mem_Addr 0, Mem_WrData 0, cpu_hold 1, busy 0, err 0, err_cause 0, word_count 0.
- Latency: a beat accepted at cycle N is written at cycle N+1. in_ready returns at N+2. Throughput is one word per 2 cycles.
- Mem_WrData and Mem_Addr are registered and stable while Mem_WrEn is high.
- cpu_hold falls one cycle after the last write (or after the last pad write).
- busy = 1 in LOAD, WRITE and PAD.
- Reset asserted mid-load aborts immediately. A partially written program remains in memory and cpu_hold returns to 1.
- A program of exactly DEPTH words with in_last on the final beat completes without error.

## Configuration
- LOADER_NOP_PAD_EN defined: after the last write, PAD writes 32'h0 to every remaining address up to DEPTH-1, one per cycle, then goes to RELEASE. word_count counts only program words.
- LOADER_NOP_PAD_EN undefined: no PAD state; WRITE goes directly to RELEASE.

## Structure
- Shared package holds: the mnemonic enum, opcode constants, the R-type func prefix 2'b11, and the err_cause constants. The CPU control decoder imports the same opcodes.
- One sub-module, instr_word_encoder: combinational mnemonic/fields to {word, illegal, zero_beq}. The FSM, counters and registers live in the top module.

## Test plan
- ADDI rs=1, rd=2, imm=16'h0005 with last → Mem_WrData 32'hC0220005 at address 0, then cpu_hold falls 1 cycle later.
- RTYPE rs=3, rd=4, rt=5, alu_op=1, then SW, then last → words 32'h80642831 and the SW word at addresses 0 and 1, word_count = 2.
- BEQ with all fields 0 → no write, err = 1, err_cause = 2, cpu_hold stays 1. A following start clears err.
- Mnemonic 15 → err_cause = 1, in_ready = 0 until start.
- DEPTH=4: five beats without last → four writes, then err_cause = 3. Four beats with last on the fourth → clean release.
- Reset pulled low during WRITE → all outputs return to reset values in the same cycle. With LOADER_NOP_PAD_EN, a 2-word program at DEPTH=4 shows 32'h0 written at addresses 2 and 3.
